// File: rtl/adc_sample_fifo_if.sv
// Sample-stream interface between the ADC capture stage, the sample FIFO and the
// downstream consumer, plus the FIFO status/overrun controls.
interface adc_sample_fifo_if #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                overrun;
    logic [7:0]          overrun_cnt;
    logic                clr_overrun;

    // FIFO side
    modport slave (
        input  in_data, in_valid, out_ready, clr_overrun,
        output out_data, out_valid, count, full, overrun, overrun_cnt
    );

    // Producer/consumer side
    modport master (
        output in_data, in_valid, out_ready, clr_overrun,
        input  out_data, out_valid, count, full, overrun, overrun_cnt
    );
endinterface

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through sample FIFO: converts offset-binary ADC codes to two's
// complement on write, buffers them, and counts samples dropped on overrun.
module adc_sample_fifo #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic            CLK,
    input  logic            RST,
    adc_sample_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned OVR_W = 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;

    logic              pop_c, push_c, drop_c;
    logic [DATA_W-1:0] wr_word_c;

    // Handshake qualification and next-state computation
    always_comb begin
        pop_c       = out_valid_q & bus.out_ready;
        push_c      = bus.in_valid & (~full_q | pop_c);
        drop_c      = bus.in_valid & full_q & ~pop_c;
        wr_word_c   = {~bus.in_data[DATA_W-1], bus.in_data[DATA_W-2:0]};

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        ovr_cnt_d   = ovr_cnt_q;

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the clearing cycle restarts the tally at one
        if (bus.clr_overrun) begin
            overrun_d = drop_c;
            ovr_cnt_d = drop_c ? OVR_W'(1) : '0;
        end else if (drop_c) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != {OVR_W{1'b1}}) ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
        end

        out_valid_d = (count_d != '0);
        full_d      = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    // Storage is not reset; a write during reset lands outside the live window
    always_ff @(posedge CLK) begin
        if (push_c) mem_q[wr_ptr_q] <= wr_word_c;
    end

    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.out_valid   = out_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = ovr_cnt_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: a per-cycle vector table plus hand-written
// sequences for wrap, fill/overrun, full push+pop, saturation and mid-run reset.
module tb_adc_sample_fifo;
    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    adc_sample_fifo_if #(.DATA_W(12), .DEPTH_LOG2(4)) bus ();

    adc_sample_fifo #(.DATA_W(12), .DEPTH_LOG2(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [11:0] din;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [11:0] ed;
        logic [4:0]  ec;
        logic        ef;
        logic        eo;
        logic [7:0]  eoc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle just past it for sampling
    task automatic cyc(input logic rst, input logic iv, input logic [11:0] din,
                       input logic rdy, input logic clr);
        RST             = rst;
        bus.in_valid    = iv;
        bus.in_data     = din;
        bus.out_ready   = rdy;
        bus.clr_overrun = clr;
        @(posedge CLK);
        #1;
        RST             = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    initial begin
        bit saw_full;
        RST             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus.clr_overrun = 1'b0;

        //           rst iv  din     rdy clr  ev  ed      ec  ef  eo  eoc
        vecs[0]  = '{1, 0, 12'h000, 0, 0,   0, 12'h000, 0,  0,  0,  0};
        vecs[1]  = '{1, 0, 12'h000, 0, 0,   0, 12'h000, 0,  0,  0,  0};
        vecs[2]  = '{0, 1, 12'h000, 0, 0,   1, 12'h800, 1,  0,  0,  0};
        vecs[3]  = '{0, 0, 12'h000, 1, 0,   0, 12'h000, 0,  0,  0,  0};
        vecs[4]  = '{0, 1, 12'h800, 1, 0,   1, 12'h000, 1,  0,  0,  0};
        vecs[5]  = '{0, 1, 12'hFFF, 0, 0,   1, 12'h000, 2,  0,  0,  0};
        vecs[6]  = '{0, 0, 12'h000, 1, 0,   1, 12'h7FF, 1,  0,  0,  0};
        vecs[7]  = '{0, 0, 12'h000, 1, 0,   0, 12'h000, 0,  0,  0,  0};
        vecs[8]  = '{0, 1, 12'h123, 1, 0,   1, 12'h923, 1,  0,  0,  0};
        vecs[9]  = '{0, 1, 12'h7FF, 1, 0,   1, 12'hFFF, 1,  0,  0,  0};
        vecs[10] = '{0, 0, 12'h000, 1, 0,   0, 12'h000, 0,  0,  0,  0};
        vecs[11] = '{0, 0, 12'h000, 0, 1,   0, 12'h000, 0,  0,  0,  0};

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            if (vecs[i].ev)
                check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].ec));
            check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].ef));
            check($sformatf("vec%0d_ovr", i), 32'(bus.overrun), 32'(vecs[i].eo));
            check($sformatf("vec%0d_ovrcnt", i), 32'(bus.overrun_cnt), 32'(vecs[i].eoc));
        end

        // Ordering and wrap: push, then pop, 40 times
        saw_full = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 12'(12'h800 + i), 0, 0);
            if (bus.full) saw_full = 1'b1;
            check("wrap_valid", 32'(bus.out_valid), 1);
            check("wrap_data", 32'(bus.out_data), 32'(i));
            cyc(0, 0, 12'h000, 1, 0);
            if (bus.full) saw_full = 1'b1;
        end
        check("wrap_count", 32'(bus.count), 0);
        check("wrap_never_full", 32'(saw_full), 0);

        // Fill and overrun
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 1, 12'(i), 0, 0);
            if (i == 16) begin
                check("fill_count16", 32'(bus.count), 16);
                check("fill_full16", 32'(bus.full), 1);
                check("fill_no_ovr", 32'(bus.overrun), 0);
            end
        end
        check("ovr_count", 32'(bus.count), 16);
        check("ovr_flag", 32'(bus.overrun), 1);
        check("ovr_cnt4", 32'(bus.overrun_cnt), 4);
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", 32'(bus.out_valid), 1);
            check("drain_data", 32'(bus.out_data), 32'(12'h800 + i));
            cyc(0, 0, 12'h000, 1, 0);
        end
        check("drain_empty", 32'(bus.out_valid), 0);
        check("drain_count", 32'(bus.count), 0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) cyc(0, 1, 12'(i), 0, 0);
        check("pp_full_before", 32'(bus.full), 1);
        cyc(0, 1, 12'hABC, 1, 0);
        check("pp_count", 32'(bus.count), 16);
        check("pp_full", 32'(bus.full), 1);
        check("pp_ovr_cnt", 32'(bus.overrun_cnt), 4);
        check("pp_head", 32'(bus.out_data), 32'(12'h802));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("pp_last", 32'(bus.out_data), 32'(12'h2BC));
            cyc(0, 0, 12'h000, 1, 0);
        end
        check("pp_drained", 32'(bus.count), 0);

        // Saturation and clear
        cyc(0, 0, 12'h000, 0, 1);
        check("clr1_ovr", 32'(bus.overrun), 0);
        check("clr1_cnt", 32'(bus.overrun_cnt), 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 12'(i), 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 12'h555, 0, 0);
        check("sat_cnt", 32'(bus.overrun_cnt), 255);
        check("sat_ovr", 32'(bus.overrun), 1);
        check("sat_count", 32'(bus.count), 16);
        cyc(0, 0, 12'h000, 0, 1);
        check("clr2_ovr", 32'(bus.overrun), 0);
        check("clr2_cnt", 32'(bus.overrun_cnt), 0);
        cyc(0, 1, 12'h555, 0, 1);
        check("clrdrop_ovr", 32'(bus.overrun), 1);
        check("clrdrop_cnt", 32'(bus.overrun_cnt), 1);

        // Mid-operation reset with 10 stored
        for (int i = 0; i < 6; i++) cyc(0, 0, 12'h000, 1, 0);
        check("mr_count10", 32'(bus.count), 10);
        cyc(1, 1, 12'h333, 0, 0);
        check("mr_count", 32'(bus.count), 0);
        check("mr_valid", 32'(bus.out_valid), 0);
        check("mr_ovr", 32'(bus.overrun), 0);
        check("mr_ovrcnt", 32'(bus.overrun_cnt), 0);
        check("mr_full", 32'(bus.full), 0);
        cyc(0, 1, 12'h555, 0, 0);
        cyc(0, 1, 12'h000, 0, 0);
        check("mr_first", 32'(bus.out_data), 32'(12'hD55));
        check("mr_count2", 32'(bus.count), 2);
        cyc(0, 0, 12'h000, 1, 0);
        check("mr_second", 32'(bus.out_data), 32'(12'h800));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
Buffers parallel samples produced by the ADC SPI capture stage and hands them to the downstream audio processing chain over a valid/ready handshake. Converts the ADC's offset-binary codes to two's-complement at the write side. Absorbs bursts and downstream stalls, and counts samples dropped on overrun. Sits directly downstream of the ADC block, in the CLK domain.

Parameters:
DATA_W, 12, sample width in bits (ADC code width).
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
in_data  input  DATA_W  offset-binary sample from the ADC stage.
in_valid  input  1  single-cycle strobe: in_data valid this cycle. No back-pressure to the ADC.
out_data  output  DATA_W  two's-complement sample at the FIFO head.
out_valid  output  1  FIFO non-empty; out_data is valid.
out_ready  input  1  consumer accepts out_data this cycle.
count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
full  output  1  count == 2^DEPTH_LOG2.
overrun  output  1  sticky: at least one sample dropped since last clear.
overrun_cnt  output  8  dropped-sample count, saturating at 255.
clr_overrun  input  1  clears overrun and overrun_cnt.

Behaviour:
- Reset (RST=1 at a CLK edge): rd_ptr, wr_ptr and count go to 0; out_valid=0; full=0; overrun=0; overrun_cnt=0. Memory contents are not reset. out_data is don't-care while out_valid=0.
- Reset mid-operation discards all stored samples. An in_valid asserted in the same cycle as RST is ignored.
- Conversion at write: stored word = {~in_data[DATA_W-1], in_data[DATA_W-2:0]}.
  - 0x000 -> 0x800 (-2048).
  - 0x800 -> 0x000.
  - 0xFFF -> 0x7FF.
- Storage: circular buffer with DEPTH_LOG2-bit pointers. Pointers wrap from 2^DEPTH_LOG2-1 to 0. Occupancy is tracked by count (or an extra pointer bit); full and empty must be unambiguous.
- Push: occurs when in_valid=1 and (full=0, or a pop occurs in the same cycle). Writes at wr_ptr, then wr_ptr increments.
- Pop: occurs when out_valid=1 and out_ready=1. rd_ptr increments. out_ready while out_valid=0 has no effect.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with simultaneous push and pop: the sample is accepted, not dropped.
- Empty with push: out_ready is ignored this cycle. Sample appears on out_data with out_valid=1 on the next cycle (1-cycle latency).
- First-word-fall-through: out_data always reflects mem[rd_ptr] while out_valid=1. out_data is stable until popped.
- Overrun (in_valid=1, full=1, no pop that cycle):
  - sample is dropped; memory and pointers unchanged.
  - overrun is set to 1.
  - overrun_cnt increments, holding at 255.
- clr_overrun:
  - clears overrun and overrun_cnt on the next edge.
  - if an overrun occurs in the same cycle, the result is overrun=1, overrun_cnt=1.
  - RST has priority over clr_overrun.
- count, full and out_valid are registered (derived from registered state, no combinational path from in_valid).

Test Plan:
- Reset then single write: RST for 2 cycles, in_valid pulse with in_data=0x000, out_ready=0. Next cycle: out_valid=1, out_data=0x800, count=1. Then out_ready=1 for 1 cycle -> out_valid=0, count=0.
- Ordering and wrap: push 40 samples 0x800+i while popping every other cycle. Output sequence must be exactly i=0..39 (values 0x000..0x027) with no loss. Pointers wrap at least twice; full never asserts.
- Fill and overrun: out_ready=0, push 20 samples 0x001..0x014.
  - count=16 and full=1 after the 16th push.
  - samples 17..20 dropped: overrun=1, overrun_cnt=4.
  - draining yields 0x801..0x810 only.
- Full plus simultaneous push/pop: at full, assert in_valid (0xABC) and out_ready in the same cycle. count stays 16, overrun unchanged, 0x2BC is the last value drained.
- Saturation and clear:
  - 300 pushes while full -> overrun_cnt=255.
  - clr_overrun -> overrun=0, overrun_cnt=0.
  - clr_overrun coincident with a drop -> overrun_cnt=1.
- Mid-operation reset: with 10 samples stored, assert RST together with in_valid. Result: count=0, out_valid=0, overrun=0; the next pushed sample is the first one output.
